// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf
//
// Generic pipeline stage register placed between two adjacent CPU stages.
// It carries an arbitrary-width stage bundle with a valid/ready handshake.
// A 2-entry buffer (main + skid) lets in_ready come straight from the state
// register, so there is no combinational path from out_ready to in_ready.
// Flush empties the stage and presents RESET_VAL (a NOP) downstream.
//
// Optional feature: define PIPE_STAGE_PERF_EN to build the stall/bubble
// performance counters. Without it both counter ports are tied to zero.
//
// Parameters:
//   DATA_W    bundle width in bits
//   RESET_VAL bundle presented on out_data whenever nothing valid is held
//   CNT_W     performance counter width
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-low clear
//   flush      in   synchronous discard of all held entries
//   in_valid   in   upstream has a bundle
//   in_ready   out  stage can accept (registered)
//   in_data    in   upstream bundle
//   out_valid  out  out_data holds a valid bundle (registered)
//   out_ready  in   downstream accepts
//   out_data   out  bundle to downstream (registered)
//   stall_cnt  out  saturating count of out_valid & ~out_ready cycles
//   bubble_cnt out  saturating count of ~out_valid & out_ready cycles
module pipe_stage_buf #(
  parameter int                 DATA_W    = 128,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // One-hot so each handshake output is a single state flop.
  typedef enum logic [2:0] {
    EMPTY = 3'b001,
    ONE   = 3'b010,
    FULL  = 3'b100
  } state_t;

  state_t              state_p0;
  state_t              state_nxt;
  logic [DATA_W-1:0]   main_p0;
  logic [DATA_W-1:0]   skid_p0;
  logic                ix;
  logic                ox;

  assign ix = in_valid & in_ready;
  assign ox = out_valid & out_ready;

  // Stage p0: occupancy state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_p0 <= EMPTY;
    end else begin
      state_p0 <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_p0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state_p0)
        EMPTY: if (ix) state_nxt = ONE;
        ONE: begin
          if (ix && !ox)      state_nxt = FULL;
          else if (!ix && ox) state_nxt = EMPTY;
        end
        FULL:  if (ox) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (state_p0 != EMPTY);
    in_ready  = (state_p0 != FULL);
  end

  // Stage p0: bundle storage. Main always holds the oldest entry, skid the
  // newer one; empty slots are kept at RESET_VAL so out_data reads as a NOP.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      main_p0 <= RESET_VAL;
      skid_p0 <= RESET_VAL;
    end else begin
      case (state_p0)
        EMPTY: begin
          if (ix) main_p0 <= in_data;
        end
        ONE: begin
          if (ix && ox) begin
            main_p0 <= in_data;
          end else if (ix) begin
            skid_p0 <= in_data;
          end else if (ox) begin
            main_p0 <= RESET_VAL;
          end
        end
        FULL: begin
          if (ox) begin
            main_p0 <= skid_p0;
            skid_p0 <= RESET_VAL;
          end
        end
        default: begin
          main_p0 <= RESET_VAL;
          skid_p0 <= RESET_VAL;
        end
      endcase
    end
  end

  assign out_data = main_p0;

`ifdef PIPE_STAGE_PERF_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [CNT_W-1:0] stall_p0;
  logic [CNT_W-1:0] bubble_p0;

  // Stage p0: performance counters; flush does not clear them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_p0  <= '0;
      bubble_p0 <= '0;
    end else begin
      if (out_valid && !out_ready)  stall_p0  <= sat_inc(stall_p0);
      if (!out_valid && out_ready)  bubble_p0 <= sat_inc(bubble_p0);
    end
  end

  assign stall_cnt  = stall_p0;
  assign bubble_cnt = bubble_p0;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;
  localparam int               DATA_W    = 16;
  localparam int               CNT_W     = 4;
  localparam logic [DATA_W-1:0] RESET_VAL = '0;
  localparam int               CNT_MAX   = (1 << CNT_W) - 1;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  pipe_stage_buf #(
    .DATA_W(DATA_W), .RESET_VAL(RESET_VAL), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: the stage is a FIFO of at most two bundles; the head
  // is what downstream sees. Counters are plain saturating integers.
  logic [DATA_W-1:0] q[$];
  int  stall_m = 0;
  int  bubble_m = 0;
  bit  started = 0;

  always @(posedge clk) begin : model
    int sz;
    bit ixm, oxm;
    sz  = q.size();
    ixm = in_valid && (sz < 2);
    oxm = out_ready && (sz > 0);
    if (!reset) begin
      q.delete();
      stall_m  = 0;
      bubble_m = 0;
      started  = 1;
    end else begin
      if (sz > 0 && !out_ready && stall_m < CNT_MAX)   stall_m++;
      if (sz == 0 && out_ready && bubble_m < CNT_MAX)  bubble_m++;
      if (flush) begin
        q.delete();
      end else begin
        if (oxm) void'(q.pop_front());
        if (ixm) q.push_back(in_data);
      end
    end
  end

  always @(negedge clk) begin : compare
    if (started) begin
      chk("in_ready",  {31'd0, in_ready},  {31'd0, (q.size() < 2)});
      chk("out_valid", {31'd0, out_valid}, {31'd0, (q.size() > 0)});
      chk("out_data",  {16'd0, out_data},  {16'd0, (q.size() > 0) ? q[0] : RESET_VAL});
`ifdef PIPE_STAGE_PERF_EN
      chk("stall_cnt",  {28'd0, stall_cnt},  stall_m);
      chk("bubble_cnt", {28'd0, bubble_cnt}, bubble_m);
`else
      chk("stall_cnt",  {28'd0, stall_cnt},  32'd0);
      chk("bubble_cnt", {28'd0, bubble_cnt}, 32'd0);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic ov, input logic ir, input logic [DATA_W-1:0] od);
    chk({name, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    chk({name, ".in_ready"},  {31'd0, in_ready},  {31'd0, ir});
    chk({name, ".out_data"},  {16'd0, out_data},  {16'd0, od});
  endtask

  logic [CNT_W-1:0] exp_stall;
  logic [CNT_W-1:0] exp_bubble;

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 16'h00A5; out_ready = 1'b1;

    // reset held for two cycles while upstream offers 0xA5
    cyc(); cyc();
    lit("reset", 1'b0, 1'b1, 16'h0000);
    reset = 1'b1;
    cyc();
    lit("post_reset", 1'b1, 1'b1, 16'h00A5);
    in_valid = 1'b0;
    cyc();

    // back-to-back streaming
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = DATA_W'(i);
      cyc();
      lit("stream", 1'b1, 1'b1, DATA_W'(i));
    end
    in_valid = 1'b0;
    cyc();
    lit("stream_drain", 1'b0, 1'b1, 16'h0000);

    // backpressure
    in_valid = 1'b1; in_data = 16'd1; out_ready = 1'b1;
    cyc(); lit("bp1", 1'b1, 1'b1, 16'd1);
    out_ready = 1'b0; in_data = 16'd2;
    cyc(); lit("bp_full", 1'b1, 1'b0, 16'd1);
    in_data = 16'd3;
    cyc(); lit("bp_hold", 1'b1, 1'b0, 16'd1);
    out_ready = 1'b1;
    cyc(); lit("bp_out2", 1'b1, 1'b1, 16'd2);
    cyc(); lit("bp_out3", 1'b1, 1'b1, 16'd3);
    in_data = 16'd4;
    cyc(); lit("bp_out4", 1'b1, 1'b1, 16'd4);
    in_valid = 1'b0;
    cyc(); lit("bp_drain", 1'b0, 1'b1, 16'h0000);

    // flush in FULL without an upstream transfer
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0011;
    cyc();
    in_data = 16'h0022;
    cyc(); lit("fl_full", 1'b1, 1'b0, 16'h0011);
    in_valid = 1'b0; flush = 1'b1;
    cyc(); lit("fl_after", 1'b0, 1'b1, 16'h0000);
    flush = 1'b0; out_ready = 1'b1;
    cyc(); lit("fl_gone", 1'b0, 1'b1, 16'h0000);

    // flush with simultaneous IX (0x77, dropped) and OX (0x55, delivered)
    in_valid = 1'b1; in_data = 16'h0055;
    cyc(); lit("fx_55", 1'b1, 1'b1, 16'h0055);
    in_data = 16'h0077; flush = 1'b1;
    cyc(); lit("fx_drop", 1'b0, 1'b1, 16'h0000);
    flush = 1'b0; in_valid = 1'b0;
    cyc(); lit("fx_none", 1'b0, 1'b1, 16'h0000);

    // reset beats flush
    in_valid = 1'b1; in_data = 16'h0033; out_ready = 1'b0;
    cyc();
    reset = 1'b0; flush = 1'b1; in_data = 16'h0044;
    cyc(); lit("rst_flush", 1'b0, 1'b1, 16'h0000);
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;

    // counters: bubbles, then saturating stall
    out_ready = 1'b1;
    cyc(); cyc(); cyc();
`ifdef PIPE_STAGE_PERF_EN
    exp_bubble = 4'd3;
`else
    exp_bubble = 4'd0;
`endif
    chk("bubble3", {28'd0, bubble_cnt}, {28'd0, exp_bubble});
    reset = 1'b0; out_ready = 1'b0;
    cyc();
    reset = 1'b1; in_valid = 1'b1; in_data = 16'h00C3;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) cyc();
`ifdef PIPE_STAGE_PERF_EN
    exp_stall = 4'd15;
`else
    exp_stall = 4'd0;
`endif
    chk("stall_sat", {28'd0, stall_cnt}, {28'd0, exp_stall});
    chk("bubble0",   {28'd0, bubble_cnt}, 32'd0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("stall_flush", {28'd0, stall_cnt}, {28'd0, exp_stall});
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    chk("stall_reset", {28'd0, stall_cnt}, 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = DATA_W'($urandom);
      flush     = ($urandom_range(0, 31) == 0);
      reset     = ($urandom_range(0, 149) != 0);
      cyc();
    end
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
